// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers, with bounded bursts.
// Optional per-requester accepted-beat counters when ARB_STATS_EN is defined.
module fifo_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  localparam int OWN_W    = $clog2(N_REQ),
  localparam int BC_W     = $clog2(MAX_BURST) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_din,
  input  logic                    fifo_full,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        accept,
  output logic                    fifo_write_enable,
  output logic [DATA_W-1:0]       fifo_din,
  output logic [OWN_W-1:0]        owner,
  output logic                    busy
`ifdef ARB_STATS_EN
  ,
  input  logic [OWN_W-1:0]        stat_sel,
  output logic [15:0]             stat_count
`endif
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [OWN_W-1:0] r_owner, w_owner_nxt;
  logic [OWN_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [BC_W-1:0]  r_beat_cnt, w_beat_cnt_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_xfer, w_last, w_rel;
  logic [OWN_W-1:0] w_pick;

  // First asserted request at or after the pointer, wrapping modulo N_REQ.
  function automatic logic [OWN_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [OWN_W-1:0] p);
    int idx;
    rr_pick = p;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % N_REQ;
      if (r[idx]) rr_pick = OWN_W'(idx);
    end
  endfunction

  assign w_pick = rr_pick(req, r_rr_ptr);
  assign w_xfer = (r_state == S_GRANT) && req[r_owner] && !fifo_full;
  assign w_last = w_xfer && (r_beat_cnt == BC_W'(MAX_BURST - 1));
  assign w_rel  = (r_state == S_GRANT) && (w_last || !req[r_owner]);

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_owner_nxt    = r_owner;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    w_busy_nxt     = r_busy;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_nxt    = S_GRANT;
          w_owner_nxt    = w_pick;
          w_gnt_nxt      = N_REQ'(1) << w_pick;
          w_busy_nxt     = 1'b1;
          w_beat_cnt_nxt = '0;
        end
      end
      S_GRANT: begin
        if (w_rel) begin
          // Owner is kept; only the pointer moves past it.
          w_state_nxt  = S_IDLE;
          w_gnt_nxt    = '0;
          w_busy_nxt   = 1'b0;
          w_rr_ptr_nxt = (r_owner == OWN_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
        end else if (w_xfer) begin
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  always_comb begin
    accept   = '0;
    fifo_din = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_xfer && (r_owner == OWN_W'(i))) begin
        accept[i] = 1'b1;
        fifo_din  = req_din[i*DATA_W +: DATA_W];
      end
    end
  end

  assign fifo_write_enable = w_xfer;
  assign gnt               = r_gnt;
  assign owner             = r_owner;
  assign busy              = r_busy;

`ifdef ARB_STATS_EN
  logic [15:0] r_stat [N_REQ];
  logic [15:0] r_stat_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) r_stat[i] <= '0;
      r_stat_count <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (accept[i] && (r_stat[i] != 16'hFFFF)) r_stat[i] <= r_stat[i] + 16'd1;
      r_stat_count <= (int'(stat_sel) < N_REQ) ? r_stat[stat_sel] : '0;
    end
  end

  assign stat_count = r_stat_count;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: cycle model compared every cycle, plus directed literal checks.
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_din;
  logic          fifo_full;
  logic [N-1:0]  gnt, accept;
  logic          fifo_write_enable;
  logic [DW-1:0] fifo_din;
  logic [1:0]    owner;
  logic          busy;
`ifdef ARB_STATS_EN
  logic [1:0]    stat_sel;
  logic [15:0]   stat_count;
`endif

  always #5 clk = ~clk;

  fifo_write_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_din(req_din), .fifo_full(fifo_full),
    .gnt(gnt), .accept(accept), .fifo_write_enable(fifo_write_enable),
    .fifo_din(fifo_din), .owner(owner), .busy(busy)
`ifdef ARB_STATS_EN
    , .stat_sel(stat_sel), .stat_count(stat_count)
`endif
  );

  // Producers: rem[i] beats left to send, dat[i] is the current beat's value.
  int          rem [N];
  logic [7:0]  dat [N];
  logic [N-1:0] acc_seen;

  always_comb begin
    req     = '0;
    req_din = '0;
    for (int i = 0; i < N; i++) begin
      req[i]            = rem[i] > 0;
      req_din[i*DW +: DW] = dat[i];
    end
  end

  int n_pass, n_tot, cyc;
  int wcyc[$], wdat[$], gcyc[$], gown[$];

  // Model state: who holds the grant, how many beats taken, where the scan starts.
  bit m_busy;
  int m_owner, m_beats, m_ptr;
  logic [N-1:0] prev_gnt;

  task automatic chk(input string nm, input int got, input int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc_seen[i]) begin
        rem[i]--;
        dat[i]++;
      end
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (((rem[0] + rem[1] + rem[2] + rem[3]) > 0 || busy) && n < max) begin
      tick();
      n++;
    end
    chk("drain_in_time", int'(n < max), 1);
    tick();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic model_cycle();
    bit ex, found;
    logic [N-1:0] eg, ea;
    eg = m_busy ? (N'(1) << m_owner) : '0;
    ex = m_busy && req[m_owner] && !fifo_full;
    ea = ex ? (N'(1) << m_owner) : '0;
    chk("gnt", int'(gnt), int'(eg));
    chk("owner", int'(owner), m_owner);
    chk("busy", int'(busy), int'(m_busy));
    chk("accept", int'(accept), int'(ea));
    chk("write_enable", int'(fifo_write_enable), int'(ex));
    if (ex) chk("fifo_din", int'(fifo_din), int'(dat[m_owner]));
    else if (!m_busy) chk("fifo_din_idle", int'(fifo_din), 0);
    if (fifo_write_enable) begin
      wcyc.push_back(cyc);
      wdat.push_back(int'(fifo_din));
    end
    if (gnt != '0 && prev_gnt == '0) begin
      gcyc.push_back(cyc);
      gown.push_back(int'(owner));
    end
    prev_gnt = gnt;
    acc_seen = accept;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
    end else if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++)
        if (!found && req[(m_ptr + k) % N]) begin
          found = 1;
          m_owner = (m_ptr + k) % N;
        end
      if (found) begin
        m_busy = 1;
        m_beats = 0;
      end
    end else begin
      if (ex) m_beats++;
      if (m_beats == MB || !req[m_owner]) begin
        m_busy = 0;
        m_ptr = (m_owner + 1) % N;
      end
    end
  endtask

  initial begin
    int w0, g0, c_req, n;
    rst = 1'b1; fifo_full = 1'b0; acc_seen = '0; prev_gnt = '0;
    n_pass = 0; n_tot = 0; cyc = 0;
    m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; dat[i] = '0; end
`ifdef ARB_STATS_EN
    stat_sel = '0;
`endif
    fork
      forever begin
        @(negedge clk);
        cyc++;
        model_cycle();
      end
    join_none

    tick(); tick();
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_owner", int'(owner), 0);
    rst = 1'b0;

    // Single requester: 6 beats, 4-beat burst, one bubble, re-grant.
    dat[0] = 8'h11; rem[0] = 6;
    w0 = wdat.size(); g0 = gcyc.size(); c_req = cyc;
    drain(60);
    chk("t1_writes", wdat.size() - w0, 6);
    if (wdat.size() - w0 >= 6) begin
      for (int k = 0; k < 6; k++) chk("t1_data", wdat[w0+k], 8'h11 + k);
      chk("t1_first_write", wcyc[w0] - c_req, 2);
      chk("t1_burst_span", wcyc[w0+3] - wcyc[w0], 3);
      chk("t1_bubble", wcyc[w0+4] - wcyc[w0+3], 2);
    end
    if (gcyc.size() - g0 >= 2) chk("t1_regrant_owner", gown[g0+1], 0);
    else chk("t1_grants", gcyc.size() - g0, 2);

    // All four requesting continuously: order 0,1,2,3,0, 4-beat bursts.
    pulse_rst();
    for (int i = 0; i < N; i++) begin rem[i] = 8; dat[i] = 8'(8'h20 * (i + 1)); end
    w0 = wdat.size(); g0 = gcyc.size();
    drain(200);
    chk("t2_writes", wdat.size() - w0, 32);
    if (gcyc.size() - g0 >= 5) begin
      for (int k = 0; k < 5; k++) chk("t2_order", gown[g0+k], k % N);
      chk("t2_handoff_gap", gcyc[g0+1] - gcyc[g0], MB + 1);
    end else chk("t2_grants", gcyc.size() - g0, 8);
    if (wdat.size() - w0 >= 5) begin
      chk("t2_beat4_data", wdat[w0+3], 8'h23);
      chk("t2_beat5_data", wdat[w0+4], 8'h40);
    end
`ifdef ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      stat_sel = 2'(i);
      tick(); tick();
      chk("stat_count", int'(stat_count), 8);
    end
`endif

    // FIFO full for 3 cycles after the second beat of requester 1.
    pulse_rst();
    dat[1] = 8'hA0; rem[1] = 4;
    w0 = wdat.size(); n = 0;
    while (rem[1] != 2 && n < 20) begin tick(); n++; end
    chk("t3_reach_beat2", rem[1], 2);
    fifo_full = 1'b1;
    repeat (3) tick();
    fifo_full = 1'b0;
    drain(40);
    chk("t3_writes", wdat.size() - w0, 4);
    if (wdat.size() - w0 >= 4) begin
      chk("t3_span", wcyc[w0+3] - wcyc[w0], 6);
      chk("t3_last_data", wdat[w0+3], 8'hA3);
    end

    // Owner 0 drops after one beat while 2 waits: release, bubble, grant 2.
    pulse_rst();
    dat[0] = 8'h55; rem[0] = 1; dat[2] = 8'h66; rem[2] = 2;
    w0 = wdat.size(); g0 = gcyc.size();
    drain(40);
    chk("t4_grants", gcyc.size() - g0, 2);
    if (gcyc.size() - g0 >= 2) begin
      chk("t4_first", gown[g0], 0);
      chk("t4_second", gown[g0+1], 2);
      chk("t4_gap", gcyc[g0+1] - gcyc[g0], 3);
    end
    if (wdat.size() - w0 >= 3) chk("t4_data", wdat[w0+1], 8'h66);

    // Reset in the middle of requester 3's burst.
    pulse_rst();
    dat[3] = 8'hC0; rem[3] = 20; n = 0;
    while (rem[3] != 18 && n < 20) begin tick(); n++; end
    chk("t5_reach_beat2", rem[3], 18);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin rem[i] = 4; dat[i] = 8'(8'h30 + 8'h10 * i); end
    tick();
    chk("t5_rst_gnt", int'(gnt), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_owner", int'(owner), 0);
    rst = 1'b0;
    g0 = gcyc.size();
    drain(300);
    if (gcyc.size() > g0) chk("t5_first_after_rst", gown[g0], 0);
    else chk("t5_grants", gcyc.size() - g0, 1);

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
